// File: rtl/spi_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// spi_pkg: FSM states, command codes and frame width shared by the SPI slave.
// Rev 1.0 - initial release
// ------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_W = 10;

endpackage
`default_nettype wire

// File: rtl/spi_miso_serializer.sv
`default_nettype none
// ------------------------------------------------------------------------
// spi_miso_serializer: loads a RAM read byte and shifts it onto MISO, MSB first.
// Rev 1.0 - initial release
// ------------------------------------------------------------------------
module spi_miso_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              abort,
  output logic              miso,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-2:0] shreg;
  logic [CNT_W-1:0]  remain;

  // done marks the cycle the final bit is on the line
  assign done = busy && (remain == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso   <= 1'b0;
      busy   <= 1'b0;
      shreg  <= '0;
      remain <= '0;
    end else if (abort) begin
      miso   <= 1'b0;
      busy   <= 1'b0;
      remain <= '0;
    end else if (load) begin
      miso   <= data[DATA_W-1];
      shreg  <= data[DATA_W-2:0];
      remain <= CNT_W'(DATA_W - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      if (remain == '0) begin
        miso <= 1'b0;
        busy <= 1'b0;
      end else begin
        miso   <= shreg[DATA_W-2];
        shreg  <= {shreg[DATA_W-3:0], 1'b0};
        remain <= remain - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// spi_slave_ctrl: SPI frame deserialiser / read-data serialiser in front of the RAM.
// Optional read-timeout via SPI_TX_TIMEOUT_EN. Rev 1.0 - initial release
// ------------------------------------------------------------------------
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              err
);
  localparam int               WORD_W   = DATA_W + 2;
  localparam int               CNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(WORD_W);

  state_e            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-2:0] shift_in;
  logic              rd_addr_done;
  logic              tx_seen;
  logic              tx_window;
  logic              ser_load;
  logic              ser_busy;
  logic              ser_done;
  logic              tmo_hit;

  // RAM response is accepted only after the strobe and only once per frame
  assign tx_window = (state == READ_DATA) && (bit_cnt == DONE_CNT) && !rx_valid &&
                     !tx_seen && !ser_busy && !SS_n;
  assign ser_load  = tx_window && tx_valid;

  spi_miso_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ser_load),
    .data  (tx_data),
    .abort (SS_n),
    .miso  (MISO),
    .busy  (ser_busy),
    .done  (ser_done)
  );

`ifdef SPI_TX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] wait_cnt;

  assign tmo_hit = tx_window && !tx_valid && (wait_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (!tx_window)
        wait_cnt <= '0;
      else if (!tx_valid)
        wait_cnt <= wait_cnt + 1'b1;
      if (tmo_hit)
        err <= 1'b1;
    end
  end
`else
  // constant false: this build waits for tx_valid indefinitely
  assign tmo_hit = (TIMEOUT_CYC < 0);
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_in     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_done <= 1'b0;
      tx_seen      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state != IDLE && SS_n) begin
        state   <= IDLE;
        bit_cnt <= '0;
        tx_seen <= 1'b0;
        if (ser_done)
          rd_addr_done <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            tx_seen <= 1'b0;
            if (!SS_n)
              state <= CHK_CMD;
          end
          CHK_CMD: begin
            if (!MOSI)
              state <= WRITE;
            else if (rd_addr_done)
              state <= READ_DATA;
            else
              state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt < LAST_BIT) begin
              shift_in <= {shift_in[WORD_W-3:0], MOSI};
              bit_cnt  <= bit_cnt + 1'b1;
            end else if (bit_cnt == LAST_BIT) begin
              rx_data  <= {shift_in, MOSI};
              rx_valid <= 1'b1;
              bit_cnt  <= DONE_CNT;
              if (state == READ_ADD)
                rd_addr_done <= 1'b1;
            end
            if (ser_load || tmo_hit)
              tx_seen <= 1'b1;
            if (ser_done || tmo_hit)
              rd_addr_done <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- Serial front-end that sits directly upstream of the dual-port RAM.
- Deserialises MOSI frames into 10-bit RAM words (rx_data / rx_valid).
- On read-data commands, captures the RAM's 8-bit response (tx_data / tx_valid) and shifts it out on MISO, MSB first.
- clk is the SPI bit clock; all sampling and driving happens on posedge clk.

Parameters:
- DATA_W, 8: RAM data/address byte width; rx_data is DATA_W+2 bits.
- TIMEOUT_CYC, 16: max cycles to wait for tx_valid (used only with the optional feature).

Ports:
- clk, input, 1: clock; MOSI sampled and MISO updated on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- SS_n, input, 1: active-low frame select; high aborts or ends a frame.
- MOSI, input, 1: serial data in, MSB first.
- MISO, output, 1: serial read data out, MSB first.
- rx_data, output, DATA_W+2: assembled word to RAM ({cmd[1:0], payload[7:0]}).
- rx_valid, output, 1: one-cycle strobe, rx_data valid.
- tx_data, input, DATA_W: read byte from RAM.
- tx_valid, input, 1: tx_data valid strobe from RAM.
- err, output, 1: sticky read-timeout flag; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE; MISO=0, rx_data=0, rx_valid=0, err=0.
  - bit_cnt=0, rd_addr_done=0, shift registers cleared.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA (enum in package).
- Transitions:
  - IDLE -> CHK_CMD when SS_n=0.
  - CHK_CMD, SS_n=1 -> IDLE.
  - CHK_CMD, MOSI=0 -> WRITE.
  - CHK_CMD, MOSI=1 and rd_addr_done=0 -> READ_ADD.
  - CHK_CMD, MOSI=1 and rd_addr_done=1 -> READ_DATA.
  - The MOSI bit consumed in CHK_CMD is a frame prefix. The following 10 bits form rx_data, whose bit 9 repeats the prefix.
- Shift-in (WRITE / READ_ADD / READ_DATA):
  - Shift MOSI into a 10-bit register each cycle; bit_cnt counts 0..9.
  - The cycle the 10th bit is sampled: rx_data <= {shift[8:0], MOSI}, and rx_valid is high the next cycle, for exactly one cycle.
  - Frame latency: SS_n fall to rx_valid = 12 cycles (1 IDLE, 1 CHK_CMD, 10 data).
  - After the strobe, bit_cnt saturates; extra MOSI bits are ignored until SS_n=1.
- READ_ADD: sets rd_addr_done=1 together with the rx_valid strobe.
- READ_DATA, after the rx_valid strobe:
  - Wait for tx_valid; on tx_valid, load tx_data into the out-shift register.
  - MISO drives bit 7 on the following cycle, then bits 6..0 on successive cycles (8 cycles total).
  - MISO returns to 0 after bit 0; rd_addr_done clears at the end of the last bit.
  - tx_valid outside the READ_DATA wait window is ignored.
- SS_n=1 in any non-IDLE state:
  - Next cycle: IDLE, bit_cnt=0, MISO=0, shift-out aborted.
  - A partial frame produces no rx_valid.
  - rd_addr_done keeps its value, except it is cleared if a READ_DATA transmission finished.
- An rx_valid already scheduled for the next cycle still fires if SS_n rises on the 10th-bit cycle.
- SS_n falling in the same cycle that a prior frame returns to IDLE is handled in the following cycle (IDLE always lasts at least 1 cycle).
- Reset asserted mid-frame: immediate return to reset values; RAM sees no strobe.

Optional Feature:
- Macro: SPI_TX_TIMEOUT_EN.
- With the macro:
  - In READ_DATA, a counter starts after rx_valid.
  - If tx_valid is not seen within TIMEOUT_CYC cycles, err sets (sticky until rst_n).
  - MISO stays 0 and the FSM waits for SS_n=1; rd_addr_done is cleared.
- Without the macro: err is tied 0 and the FSM waits indefinitely for tx_valid.

Decomposition:
- Package spi_pkg:
  - state_e enum.
  - Command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - Localparam FRAME_W=10.
- One sub-module, spi_miso_serializer: load on tx_valid, 8-bit parallel-to-serial, busy/done outputs, abort input driven by SS_n.

Test Plan:
- Write address: SS_n low, MOSI 0 then 00_1010_0101 -> rx_data=10'h0A5, rx_valid one cycle at cycle 12; no err; MISO=0.
- Write data: frame 0, 01_0011_1100 -> rx_data=10'h13C strobe; RAM location 0xA5 later reads 0x3C.
- Read address then read data: frame 1, 10_1010_0101 sets rd_addr_done. Frame 1, 11_xxxx_xxxx strobes, RAM returns 0x3C -> MISO shows 0,0,1,1,1,1,0,0 over 8 cycles starting the cycle after tx_valid; rd_addr_done=0 after.
- Abort: SS_n rises after 5 data bits -> no rx_valid, FSM in IDLE next cycle, next full frame decodes correctly.
- Reset mid READ_DATA shift (after bit 3) -> MISO=0, rx_valid=0, rd_addr_done=0 immediately; the next MOSI=1 frame enters READ_ADD.
- SPI_TX_TIMEOUT_EN with TIMEOUT_CYC=16: read-data frame with tx_valid held 0 -> err=1 after 16 cycles and stays 1; MISO stays 0.
